shift_add_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier built around a left-shifting multiplicand register. On each iteration it consumes the multiplicand shifted left by one and adds it into an accumulator whenever the current multiplier bit is 1. It sits downstream of the shift-left register stage and produces one `2*Word_Length`-bit product per `start` request, with fixed latency and a start/done handshake.

---
 rtl/shift_add_multiplier_if.sv | 33 +++
 rtl/shift_add_multiplier.sv | 105 ++++++++++
 tb/tb_shift_add_multiplier.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
//   Request/response bundle for the shift-and-add multiplier.
//   master : drives start and both operands, observes the result and status.
//   slave  : the multiplier itself.
//   Signals:
//     start        - request a new multiplication (sampled on rising clk)
//     Multiplicand - unsigned operand A, Word_Length bits
//     Multiplier   - unsigned operand B, Word_Length bits
//     Product      - registered A*B, 2*Word_Length bits
//     busy         - high while an iteration sequence is running
//     done         - one-cycle completion pulse
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
  parameter int Word_Length = 8
);
  logic                       start;
  logic [Word_Length-1:0]     Multiplicand;
  logic [Word_Length-1:0]     Multiplier;
  logic [2*Word_Length-1:0]   Product;
  logic                       busy;
  logic                       done;

  modport master (
    output start, Multiplicand, Multiplier,
    input  Product, busy, done
  );

  modport slave (
    input  start, Multiplicand, Multiplier,
    output Product, busy, done
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned multiplier. The multiplicand sits zero-extended in a
//   2*Word_Length register that shifts left once per iteration; whenever the
//   current multiplier LSB is 1 the shifted multiplicand is added into the
//   accumulator. Exactly Word_Length iterations per product, no early exit.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-low reset, clears all state
//     bus   - slave side of shift_add_multiplier_if (start/operands in,
//             Product/busy/done out)
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int Word_Length = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_multiplier_if.slave bus
);

  localparam int PW = 2 * Word_Length;
  // Wide enough to hold Word_Length so the final increment never wraps.
  localparam int CW = $clog2(Word_Length + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]          acc;
  logic [PW-1:0]          mcand;
  logic [PW-1:0]          product_r;
  logic [Word_Length-1:0] mplier;
  logic [CW-1:0]          count;

  logic          accept;
  logic          last_iter;
  logic [PW-1:0] acc_sum;

  // start is honoured only outside RUN; a request during RUN is dropped.
  assign accept    = (state != RUN) && bus.start;
  assign last_iter = (state == RUN) && (count == CW'(Word_Length - 1));
  // Cannot overflow: the full sum of all partial products fits in PW bits.
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      product_r <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{Word_Length{1'b0}}, bus.Multiplicand};
      mplier <= bus.Multiplier;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      // Product includes this iteration's add and holds until the next finish.
      if (last_iter) product_r <= acc_sum;
    end
  end

  assign bus.Product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier at Word_Length = 8. A vector table
//   drives complete multiplications with hand-computed products; separate
//   sequences cover an ignored start, back-to-back operation and an abort by
//   reset in the middle of a computation.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic clk;
  logic reset;

  shift_add_multiplier_if #(.Word_Length(W)) bus ();

  shift_add_multiplier #(.Word_Length(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] prev_product;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Full transaction: start on one edge, then check status every cycle up to
  // one cycle past done. Operands are scrambled right after the accept edge.
  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string name);
    @(negedge clk);
    bus.start = 1'b1; bus.Multiplicand = a; bus.Multiplier = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.Multiplicand = ~a; bus.Multiplier = ~b;
    check({name, "_e0_busy"}, 32'(bus.busy), 1);
    check({name, "_e0_done"}, 32'(bus.done), 0);
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      check($sformatf("%s_e%0d_busy", name, k), 32'(bus.busy), 1);
      check($sformatf("%s_e%0d_done", name, k), 32'(bus.done), 0);
      check($sformatf("%s_e%0d_hold", name, k), 32'(bus.Product), 32'(prev_product));
    end
    @(negedge clk);
    check({name, "_done"},    32'(bus.done),    1);
    check({name, "_busy_lo"}, 32'(bus.busy),    0);
    check({name, "_product"}, 32'(bus.Product), 32'(exp));
    @(negedge clk);
    check({name, "_done_lo"}, 32'(bus.done),    0);
    check({name, "_after"},   32'(bus.Product), 32'(exp));
    prev_product = exp;
  endtask

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143,   name: "v13x11"};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'd65025, name: "v255x255"};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0,     name: "v0x200"};
    vecs[3] = '{a: 8'd1,   b: 8'd255, exp: 16'd255,   name: "v1x255"};
    vecs[4] = '{a: 8'd128, b: 8'd2,   exp: 16'd256,   name: "v128x2"};
    vecs[5] = '{a: 8'd200, b: 8'd3,   exp: 16'd600,   name: "v200x3"};

    bus.start = 1'b0; bus.Multiplicand = '0; bus.Multiplier = '0;
    prev_product = '0;

    // Reset held with clock running.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_product", 32'(bus.Product), 0);
    check("rst_busy",    32'(bus.busy),    0);
    check("rst_done",    32'(bus.done),    0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_product", 32'(bus.Product), 0);
    check("idle_busy",    32'(bus.busy),    0);
    check("idle_done",    32'(bus.done),    0);

    foreach (vecs[i]) run_vec(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // start during RUN with new operands must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.Multiplicand = 8'd7; bus.Multiplier = 8'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);                 // after edge 1
    @(negedge clk);                 // after edge 2
    bus.start = 1'b1; bus.Multiplicand = 8'd100; bus.Multiplier = 8'd100;
    @(negedge clk);                 // after edge 3
    bus.start = 1'b0;
    check("ign_busy_e3", 32'(bus.busy), 1);
    repeat (W - 3) @(negedge clk);  // after edge 8
    check("ign_done",    32'(bus.done),    1);
    check("ign_product", 32'(bus.Product), 63);
    @(negedge clk);
    check("ign_no_restart", 32'(bus.busy), 0);
    check("ign_done_lo",    32'(bus.done), 0);
    prev_product = 16'd63;

    // Back-to-back: second start lands in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.Multiplicand = 8'd3; bus.Multiplier = 8'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W) @(negedge clk);      // after edge 8
    check("b2b_done1",    32'(bus.done),    1);
    check("b2b_product1", 32'(bus.Product), 15);
    bus.start = 1'b1; bus.Multiplicand = 8'd6; bus.Multiplier = 8'd7;
    @(negedge clk);                 // after edge 9
    bus.start = 1'b0;
    check("b2b_rebusy",  32'(bus.busy),    1);
    check("b2b_done_lo", 32'(bus.done),    0);
    check("b2b_hold",    32'(bus.Product), 15);
    repeat (W - 1) @(negedge clk);  // after edge 16
    check("b2b_not_yet", 32'(bus.done), 0);
    @(negedge clk);                 // after edge 17
    check("b2b_done2",    32'(bus.done),    1);
    check("b2b_product2", 32'(bus.Product), 42);
    @(negedge clk);
    check("b2b_idle", 32'(bus.busy), 0);

    // Abort mid-operation with asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1; bus.Multiplicand = 8'd50; bus.Multiplier = 8'd50;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);      // after edge 4
    check("abort_busy_pre", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("abort_product", 32'(bus.Product), 0);
    check("abort_busy",    32'(bus.busy),    0);
    check("abort_done",    32'(bus.done),    0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("post_abort_%0d_done", k), 32'(bus.done), 0);
      check($sformatf("post_abort_%0d_busy", k), 32'(bus.busy), 0);
    end
    check("post_abort_product", 32'(bus.Product), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
